// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arithmetic/shift ops plus an iterative
// shift-add multiply, with valid/ready handshakes on both the operand and the
// result side. Results and flags are held in registers until consumed.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic             accept;
  logic             is_mul;

  // Multiplier state: multiplicand shifts left, multiplier shifts right,
  // so bit 0 of the multiplier always selects the current partial product.
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] addend;
  logic [CW-1:0]      cnt_reg;

  logic [WIDTH-1:0] result_reg;
  logic             overflow_reg;
  logic             carry_reg;
  logic             zero_reg;

  // Single-cycle datapath signals
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;
  logic             sltu_bit;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;
  logic             alu_carry;

  assign accept = in_valid & in_ready;
  assign is_mul = (ALUop == OP_MUL);

  assign Result   = result_reg;
  assign Overflow = overflow_reg;
  assign CarryOut = carry_reg;
  assign Zero     = zero_reg;

  // Partial product gated by the current multiplier bit
  genvar gi;
  generate
    for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  assign prod_next = prod_reg + addend;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) state_next = is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (cnt_reg == CW'(1)) state_next = S_DONE;
      end
      S_DONE: begin
        if (accept)         state_next = is_mul ? S_MUL : S_DONE;
        else if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready  = resetn & ((state_reg == S_IDLE) | ((state_reg == S_DONE) & out_ready));
    busy      = (state_reg == S_MUL);
    out_valid = (state_reg == S_DONE);
  end

  // Single-cycle ALU: compare ops reuse the A + ~B + 1 subtractor
  always_comb begin
    sum_ext  = {1'b0, A} + {1'b0, B};
    diff_ext = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
    add_ovf  = (A[WIDTH-1] == B[WIDTH-1]) & (sum_ext[WIDTH-1] ^ A[WIDTH-1]);
    sub_ovf  = (A[WIDTH-1] ^ B[WIDTH-1]) & (diff_ext[WIDTH-1] ^ A[WIDTH-1]);
    // Differing signs decide SLT directly, so A-B overflow cannot flip it
    slt_bit  = (A[WIDTH-1] ^ B[WIDTH-1]) ? A[WIDTH-1] : diff_ext[WIDTH-1];
    sltu_bit = ~diff_ext[WIDTH];
    shamt    = B[SW-1:0];
    alu_result = '0;
    alu_ovf    = 1'b0;
    alu_carry  = 1'b0;
    case (ALUop)
      OP_AND:  alu_result = A & B;
      OP_OR:   alu_result = A | B;
      OP_ADD: begin
        alu_result = sum_ext[WIDTH-1:0];
        alu_ovf    = add_ovf;
        alu_carry  = sum_ext[WIDTH];
      end
      OP_XOR:  alu_result = A ^ B;
      OP_NOR:  alu_result = ~(A | B);
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_SUB: begin
        alu_result = diff_ext[WIDTH-1:0];
        alu_ovf    = sub_ovf;
        alu_carry  = diff_ext[WIDTH];
      end
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL:  alu_result = A << shamt;
      OP_SRL:  alu_result = A >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(A) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  // Operand capture, multiply iteration and result/flag registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      prod_reg     <= '0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      carry_reg    <= 1'b0;
      zero_reg     <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand_reg  <= {{WIDTH{1'b0}}, A};
        mplier_reg <= B;
        prod_reg   <= '0;
        cnt_reg    <= CW'(WIDTH);
      end else begin
        result_reg   <= alu_result;
        overflow_reg <= alu_ovf;
        carry_reg    <= alu_carry;
        zero_reg     <= (alu_result == '0);
      end
    end else if (state_reg == S_MUL) begin
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_reg - CW'(1);
      // Last step: publish the product directly from the adder output
      if (cnt_reg == CW'(1)) begin
        result_reg   <= prod_next[WIDTH-1:0];
        overflow_reg <= |prod_next[2*WIDTH-1:WIDTH];
        carry_reg    <= 1'b0;
        zero_reg     <= (prod_next[WIDTH-1:0] == '0);
      end
    end
  end

endmodule
